// File: rtl/display_scan_controller.sv
// Frame-scan controller: per-channel slot selects, pixel/line counts, blanking, vsync and
// ping-pong buffer read/release. Optional `frame_cnt` output via SCAN_FRAME_CNT_EN.
//
// state    | meaning
// S_IDLE   | after reset, waiting for first enabled cycle
// S_VBLANK | vertical blank, blank=1, buffer sampled on last cycle
// S_ACTIVE | scanning buffer `cur`, re one-hot, blank=0
module display_scan_controller #(
  parameter int CH     = 3,
  parameter int PX_W   = 8,
  parameter int LN_W   = 8,
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [PX_W-1:0]   act_px,
  input  logic [LN_W-1:0]   act_ln,
  input  logic [LN_W-1:0]   vb_ln,
  input  logic [1:0]        buf_ready,
  output logic [1:0]        re,
  output logic [ADDR_W-1:0] addr,
  output logic [CH-1:0]     ch_sel,
  output logic              blank,
  output logic              vsync,
  output logic [PX_W-1:0]   px_cnt,
  output logic [LN_W-1:0]   ln_cnt,
  output logic [1:0]        buf_release,
`ifdef SCAN_FRAME_CNT_EN
  output logic [15:0]       frame_cnt,
`endif
  output logic              underrun
);

  localparam int CI_W = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_VBLANK, S_ACTIVE} state_t;

  state_t            state_q, state_d;
  logic              cur_q, cur_d;
  logic [CI_W-1:0]   ch_idx_q, ch_idx_d;
  logic [PX_W-1:0]   px_q, px_d, lat_px_q, lat_px_d;
  logic [LN_W-1:0]   ln_q, ln_d, lat_act_q, lat_act_d, lat_vb_q, lat_vb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        re_q, re_d, rel_q, rel_d;
  logic [CH-1:0]     ch_sel_q, ch_sel_d;
  logic              blank_q, blank_d, vsync_q, vsync_d, und_q, und_d;
  logic              enter_vb, last_slot, last_px, last_ln;
  logic [LN_W-1:0]   ln_end;

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    ch_idx_d  = ch_idx_q;
    px_d      = px_q;
    ln_d      = ln_q;
    addr_d    = addr_q;
    lat_px_d  = lat_px_q;
    lat_act_d = lat_act_q;
    lat_vb_d  = lat_vb_q;
    re_d      = 2'b00;
    blank_d   = 1'b1;
    vsync_d   = 1'b0;
    rel_d     = 2'b00;
    und_d     = 1'b0;
    enter_vb  = 1'b0;

    ln_end    = ((state_q == S_ACTIVE) ? lat_act_q : lat_vb_q) - LN_W'(1);
    last_slot = (ch_idx_q == CI_W'(CH - 1));
    last_px   = (px_q == lat_px_q - PX_W'(1));
    last_ln   = (ln_q == ln_end);

    if (enable) begin
      if (state_q == S_IDLE) begin
        enter_vb = 1'b1;
      end else begin
        if (!last_slot) begin
          ch_idx_d = ch_idx_q + CI_W'(1);
        end else begin
          ch_idx_d = '0;
          if (state_q == S_ACTIVE) addr_d = addr_q + ADDR_W'(1);
          if (!last_px) begin
            px_d = px_q + PX_W'(1);
          end else begin
            px_d = '0;
            if (!last_ln) begin
              ln_d = ln_q + LN_W'(1);
            end else begin
              ln_d = '0;
              if (state_q == S_VBLANK) begin
                if (buf_ready[cur_q]) begin
                  state_d = S_ACTIVE;
                end else begin
                  und_d    = 1'b1;
                  enter_vb = 1'b1;
                end
              end else begin
                rel_d[cur_q] = 1'b1;
                cur_d        = ~cur_q;
                addr_d       = '0;
                enter_vb     = 1'b1;
              end
            end
          end
        end
      end

      // Geometry is captured at every VBLANK entry, including underrun restarts.
      if (enter_vb) begin
        state_d   = S_VBLANK;
        vsync_d   = 1'b1;
        lat_px_d  = (act_px == '0) ? PX_W'(1) : act_px;
        lat_act_d = (act_ln == '0) ? LN_W'(1) : act_ln;
        lat_vb_d  = (vb_ln == '0) ? LN_W'(1) : vb_ln;
      end

      re_d    = (state_d == S_ACTIVE) ? {cur_d, ~cur_d} : 2'b00;
      blank_d = (state_d != S_ACTIVE);
    end

    ch_sel_d = CH'(1) << ch_idx_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cur_q     <= 1'b0;
      ch_idx_q  <= '0;
      px_q      <= '0;
      ln_q      <= '0;
      addr_q    <= '0;
      lat_px_q  <= PX_W'(1);
      lat_act_q <= LN_W'(1);
      lat_vb_q  <= LN_W'(1);
      re_q      <= 2'b00;
      ch_sel_q  <= CH'(1);
      blank_q   <= 1'b1;
      vsync_q   <= 1'b0;
      rel_q     <= 2'b00;
      und_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      ch_idx_q  <= ch_idx_d;
      px_q      <= px_d;
      ln_q      <= ln_d;
      addr_q    <= addr_d;
      lat_px_q  <= lat_px_d;
      lat_act_q <= lat_act_d;
      lat_vb_q  <= lat_vb_d;
      re_q      <= re_d;
      ch_sel_q  <= ch_sel_d;
      blank_q   <= blank_d;
      vsync_q   <= vsync_d;
      rel_q     <= rel_d;
      und_q     <= und_d;
    end
  end

`ifdef SCAN_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (rel_d != 2'b00) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign re          = re_q;
  assign addr        = addr_q;
  assign ch_sel      = ch_sel_q;
  assign blank       = blank_q;
  assign vsync       = vsync_q;
  assign px_cnt      = px_q;
  assign ln_cnt      = ln_q;
  assign buf_release = rel_q;
  assign underrun    = und_q;

endmodule
